// File: rtl/regfile_pkg.sv
// Shared defaults and the slot record for the register-file write-back arbiter.
// Contents: DATA_WIDTH / SELECT_SIZE defaults, NUM_REQ requester count, and
// slot_t, the record layout of one holding slot in the default configuration.
package regfile_pkg;

   localparam int unsigned DATA_WIDTH  = 16;
   localparam int unsigned SELECT_SIZE = 3;
   localparam int unsigned NUM_REQ     = 2;

   // One holding slot: occupancy, waited-a-cycle flag, destination and data.
   typedef struct packed {
      logic                   full;
      logic                   age;
      logic [SELECT_SIZE-1:0] dst;
      logic [DATA_WIDTH-1:0]  data;
   } slot_t;

endpackage

// File: rtl/regfile_wb_slot.sv
// One write-back holding slot: captures a request, holds it until granted.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   accept            - capture dst_in/data_in at this edge (may refill on grant)
//   grant             - the held entry commits at this edge
//   dst_in, data_in   - request payload
//   full, age         - occupancy; age=1 once the entry has lost arbitration
//   dst, data         - held payload
module regfile_wb_slot
   import regfile_pkg::*;
#(
   parameter int unsigned DataWidth  = DATA_WIDTH,
   parameter int unsigned SelectSize = SELECT_SIZE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  accept,
   input  logic                  grant,
   input  logic [SelectSize-1:0] dst_in,
   input  logic [DataWidth-1:0]  data_in,
   output logic                  full,
   output logic                  age,
   output logic [SelectSize-1:0] dst,
   output logic [DataWidth-1:0]  data
);

   // Capture has priority over release so a granted slot can refill the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         full <= 1'b0;
         age  <= 1'b0;
         dst  <= '0;
         data <= '0;
      end else if (accept) begin
         full <= 1'b1;
         age  <= 1'b0;
         dst  <= dst_in;
         data <= data_in;
      end else if (grant) begin
         full <= 1'b0;
         age  <= 1'b0;
      end else if (full) begin
         age  <= 1'b1;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester write-back arbiter in front of an active-low-WE register file.
// Ports:
//   Clk, Reset                 - clock, synchronous active-high reset
//   ReqN_Valid/Ready/Dst/Data  - request handshake and payload (0 = ALU, 1 = load)
//   REG_WE, REG_Dst, DIn       - register-file write port (combinational grant)
//   Pending                    - one bit per register with an uncommitted write
// Optional build macro REGFILE_WB_ARB_RR_EN: round-robin on equal-age ties
// (requester 0 first after reset); otherwise requester 0 always wins ties.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned DataWidth  = DATA_WIDTH,
   parameter int unsigned SelectSize = SELECT_SIZE
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         Req0_Valid,
   output logic                         Req0_Ready,
   input  logic [SelectSize-1:0]        Req0_Dst,
   input  logic [DataWidth-1:0]         Req0_Data,
   input  logic                         Req1_Valid,
   output logic                         Req1_Ready,
   input  logic [SelectSize-1:0]        Req1_Dst,
   input  logic [DataWidth-1:0]         Req1_Data,
   output logic                         REG_WE,
   output logic [SelectSize-1:0]        REG_Dst,
   output logic [DataWidth-1:0]         DIn,
   output logic [(2**SelectSize)-1:0]   Pending
);

   logic [NUM_REQ-1:0]                 valid;
   logic [NUM_REQ-1:0]                 ready;
   logic [NUM_REQ-1:0]                 accept;
   logic [NUM_REQ-1:0]                 grant;
   logic [NUM_REQ-1:0]                 full;
   logic [NUM_REQ-1:0]                 age;
   logic [NUM_REQ-1:0][SelectSize-1:0] req_dst;
   logic [NUM_REQ-1:0][SelectSize-1:0] slot_dst;
   logic [NUM_REQ-1:0][DataWidth-1:0]  req_data;
   logic [NUM_REQ-1:0][DataWidth-1:0]  slot_data;
   logic                               tie_pick1;

   assign valid    = {Req1_Valid, Req0_Valid};
   assign req_dst  = {Req1_Dst, Req0_Dst};
   assign req_data = {Req1_Data, Req0_Data};

   // A slot accepts when empty or when its current entry leaves this edge.
   assign ready      = {NUM_REQ{~Reset}} & (~full | grant);
   assign accept     = valid & ready;
   assign Req0_Ready = ready[0];
   assign Req1_Ready = ready[1];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
      regfile_wb_slot #(
         .DataWidth  (DataWidth),
         .SelectSize (SelectSize)
      ) u_slot (
         .clk     (Clk),
         .reset   (Reset),
         .accept  (accept[i]),
         .grant   (grant[i]),
         .dst_in  (req_dst[i]),
         .data_in (req_data[i]),
         .full    (full[i]),
         .age     (age[i]),
         .dst     (slot_dst[i]),
         .data    (slot_data[i])
      );
   end

   // A slot that already lost once is strictly older; both can never be aged.
   always_comb begin
      grant = '0;
      if (!Reset) begin
         if (full[0] && full[1]) begin
            if (age[0] != age[1]) grant = age[1] ? 2'b10 : 2'b01;
            else                  grant = tie_pick1 ? 2'b10 : 2'b01;
         end else begin
            grant = full;
         end
      end
   end

`ifdef REGFILE_WB_ARB_RR_EN
   logic rr_q;

   // After a tie won by requester 0, requester 1 gets the next tie, and vice versa.
   always_ff @(posedge Clk) begin
      if (Reset)                                 rr_q <= 1'b0;
      else if (full[0] && full[1] && age[0] == age[1]) rr_q <= grant[0];
   end

   assign tie_pick1 = rr_q;
`else
   assign tie_pick1 = 1'b0;
`endif

   // Register-file write port driven from the granted slot, zero when idle.
   always_comb begin
      REG_WE  = ~|grant;
      REG_Dst = '0;
      DIn     = '0;
      if (grant[1]) begin
         REG_Dst = slot_dst[1];
         DIn     = slot_data[1];
      end else if (grant[0]) begin
         REG_Dst = slot_dst[0];
         DIn     = slot_data[0];
      end
   end

   // Scoreboard of registers with a write still sitting in a slot.
   always_comb begin
      Pending = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (full[i]) Pending[slot_dst[i]] = 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: per-cycle vector table plus reset and
// tie-order sequences, with a register-file model fed from the write port.
module tb_regfile_wb_arbiter;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Req0_Valid, Req1_Valid;
   logic        Req0_Ready, Req1_Ready;
   logic [2:0]  Req0_Dst, Req1_Dst;
   logic [15:0] Req0_Data, Req1_Data;
   logic        REG_WE;
   logic [2:0]  REG_Dst;
   logic [15:0] DIn;
   logic [7:0]  Pending;

   int checks   = 0;
   int failures = 0;

   always #5 Clk = ~Clk;

   regfile_wb_arbiter dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Req0_Valid (Req0_Valid),
      .Req0_Ready (Req0_Ready),
      .Req0_Dst   (Req0_Dst),
      .Req0_Data  (Req0_Data),
      .Req1_Valid (Req1_Valid),
      .Req1_Ready (Req1_Ready),
      .Req1_Dst   (Req1_Dst),
      .Req1_Data  (Req1_Data),
      .REG_WE     (REG_WE),
      .REG_Dst    (REG_Dst),
      .DIn        (DIn),
      .Pending    (Pending)
   );

   // External register file plus a log of every committed destination.
   logic [15:0] rf [8] = '{default: 16'h0000};
   logic [2:0]  commit_dst [$];

   always @(posedge Clk) begin
      if (REG_WE === 1'b0) begin
         rf[REG_Dst] <= DIn;
         commit_dst.push_back(REG_Dst);
      end
   end

   typedef struct {
      logic        v0;
      logic [2:0]  d0;
      logic [15:0] x0;
      logic        v1;
      logic [2:0]  d1;
      logic [15:0] x1;
      logic        we;
      logic [2:0]  dst;
      logic [15:0] din;
      logic [7:0]  pend;
      logic        r0;
      logic        r1;
   } vec_t;

   vec_t tbl [16];

   function automatic vec_t mk(input logic v0, input logic [2:0] d0, input logic [15:0] x0,
                               input logic v1, input logic [2:0] d1, input logic [15:0] x1,
                               input logic we, input logic [2:0] dst, input logic [15:0] din,
                               input logic [7:0] pend, input logic r0, input logic r1);
      vec_t v;
      v.v0 = v0; v.d0 = d0; v.x0 = x0;
      v.v1 = v1; v.d1 = d1; v.x1 = x1;
      v.we = we; v.dst = dst; v.din = din; v.pend = pend; v.r0 = r0; v.r1 = r1;
      return v;
   endfunction

   task automatic chk(input string name, input int step, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d got=0x%0h want=0x%0h", name, step, act, exp);
      end
   endtask

   task automatic drive(input logic v0, input logic [2:0] d0, input logic [15:0] x0,
                        input logic v1, input logic [2:0] d1, input logic [15:0] x1);
      Req0_Valid = v0; Req0_Dst = d0; Req0_Data = x0;
      Req1_Valid = v1; Req1_Dst = d1; Req1_Data = x1;
   endtask

   int ord [6];

   initial begin
      //            v0 d0 x0        v1 d1 x1         we dst din       pend   r0 r1
      tbl[0]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 8'h00, 1, 1);
      tbl[1]  = mk(1, 2, 16'h00A0, 0, 0, 16'h0000, 1, 0, 16'h0000, 8'h00, 1, 1);
      tbl[2]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 2, 16'h00A0, 8'h04, 1, 1);
      tbl[3]  = mk(1, 1, 16'h000A, 0, 0, 16'h0000, 1, 0, 16'h0000, 8'h00, 1, 1);
      tbl[4]  = mk(0, 0, 16'h0000, 1, 3, 16'h1234, 0, 1, 16'h000A, 8'h02, 1, 1);
      tbl[5]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 3, 16'h1234, 8'h08, 1, 1);
      tbl[6]  = mk(0, 0, 16'h0000, 1, 6, 16'hBEEF, 1, 0, 16'h0000, 8'h00, 1, 1);
      tbl[7]  = mk(1, 6, 16'hCAFE, 0, 0, 16'h0000, 0, 6, 16'hBEEF, 8'h40, 1, 1);
      tbl[8]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 6, 16'hCAFE, 8'h40, 1, 1);
      tbl[9]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 8'h00, 1, 1);
      tbl[10] = mk(1, 0, 16'h0101, 1, 7, 16'h0777, 1, 0, 16'h0000, 8'h00, 1, 1);
      tbl[11] = mk(1, 5, 16'h0505, 1, 4, 16'h0404, 0, 0, 16'h0101, 8'h81, 1, 0);
      tbl[12] = mk(0, 0, 16'h0000, 1, 4, 16'h0404, 0, 7, 16'h0777, 8'hA0, 0, 1);
      tbl[13] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 5, 16'h0505, 8'h30, 1, 0);
      tbl[14] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 4, 16'h0404, 8'h10, 1, 1);
      tbl[15] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 8'h00, 1, 1);

      // Reset and check the write port stays idle while it is held.
      Reset = 1'b1;
      drive(0, 0, 16'h0, 0, 0, 16'h0);
      repeat (2) @(posedge Clk);
      #1;
      @(negedge Clk);
      chk("we_during_reset", -1, 32'(REG_WE), 32'd1);
      @(posedge Clk);
      #1;
      Reset = 1'b0;

      // Per-cycle vectors: inputs applied after the edge, outputs sampled mid-cycle.
      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].v0, tbl[i].d0, tbl[i].x0, tbl[i].v1, tbl[i].d1, tbl[i].x1);
         @(negedge Clk);
         chk("reg_we",     i, 32'(REG_WE),     32'(tbl[i].we));
         chk("reg_dst",    i, 32'(REG_Dst),    32'(tbl[i].dst));
         chk("din",        i, 32'(DIn),        32'(tbl[i].din));
         chk("pending",    i, 32'(Pending),    32'(tbl[i].pend));
         chk("req0_ready", i, 32'(Req0_Ready), 32'(tbl[i].r0));
         chk("req1_ready", i, 32'(Req1_Ready), 32'(tbl[i].r1));
         @(posedge Clk);
         #1;
      end

      chk("commit_count_tbl", 16, 32'(commit_dst.size()), 32'd9);
      chk("rf2", 16, 32'(rf[2]), 32'h00A0);
      chk("rf1", 16, 32'(rf[1]), 32'h000A);
      chk("rf3", 16, 32'(rf[3]), 32'h1234);
      chk("rf6", 16, 32'(rf[6]), 32'hCAFE);
      chk("rf0", 16, 32'(rf[0]), 32'h0101);
      chk("rf7", 16, 32'(rf[7]), 32'h0777);

      // Reset with both slots full: nothing commits, state clears.
      drive(1, 1, 16'h5555, 1, 2, 16'h6666);
      @(posedge Clk);
      #1;
      Reset = 1'b1;
      drive(0, 0, 16'h0, 0, 0, 16'h0);
      @(negedge Clk);
      chk("rst_full_we",      20, 32'(REG_WE),  32'd1);
      chk("rst_full_pending", 20, 32'(Pending), 32'h06);
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      @(negedge Clk);
      chk("post_rst_pending", 21, 32'(Pending),    32'h00);
      chk("post_rst_we",      21, 32'(REG_WE),     32'd1);
      chk("post_rst_ready0",  21, 32'(Req0_Ready), 32'd1);
      chk("post_rst_ready1",  21, 32'(Req1_Ready), 32'd1);
      chk("post_rst_commits", 21, 32'(commit_dst.size()), 32'd9);
      chk("post_rst_rf1",     21, 32'(rf[1]), 32'h000A);
      chk("post_rst_rf2",     21, 32'(rf[2]), 32'h00A0);
      @(posedge Clk);
      #1;

      // Three same-edge pairs; requester 0 writes R4, requester 1 writes R5.
      for (int r = 0; r < 3; r++) begin
         drive(1, 4, 16'h1111, 1, 5, 16'h2222);
         @(posedge Clk);
         #1;
         drive(0, 0, 16'h0, 0, 0, 16'h0);
         repeat (3) @(posedge Clk);
         #1;
      end

`ifdef REGFILE_WB_ARB_RR_EN
      ord = '{0, 1, 1, 0, 0, 1};
`else
      ord = '{0, 1, 0, 1, 0, 1};
`endif
      chk("tie_commit_count", 30, 32'(commit_dst.size()), 32'd15);
      if (commit_dst.size() >= 15) begin
         for (int k = 0; k < 6; k++)
            chk("tie_order", 30 + k, 32'(commit_dst[9 + k]), 32'(4 + ord[k]));
      end
      chk("rf4", 40, 32'(rf[4]), 32'h1111);
      chk("rf5", 40, 32'(rf[5]), 32'h2222);
      @(negedge Clk);
      chk("end_pending", 41, 32'(Pending), 32'h00);
      chk("end_we",      41, 32'(REG_WE),  32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DataWidth, default 16, giving the register data width.
REQ-002 The block SHALL have parameter SelectSize, default 3, giving the register select width (8 registers).
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-004 Port Clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-005 Port Reset, input, 1 bit: synchronous active-high reset.
REQ-006 Ports Req0_Valid / Req1_Valid, input, 1 bit each: write-back request from the ALU / load path.
REQ-007 Ports Req0_Ready / Req1_Ready, output, 1 bit each: the slot can accept a request this cycle.
REQ-008 Ports Req0_Dst / Req1_Dst, input, SelectSize bits each: destination register.
REQ-009 Ports Req0_Data / Req1_Data, input, DataWidth bits each: write data.
REQ-010 Port REG_WE, output, 1 bit: register-file write enable, active-low.
REQ-011 Port REG_Dst, output, SelectSize bits: register-file destination select.
REQ-012 Port DIn, output, DataWidth bits: register-file write data.
REQ-013 Port Pending, output, 2^SelectSize bits: bit r is set while an accepted write to register r is not yet committed.

Function
REQ-014 Each requester SHALL own one holding slot (Full, Dst, Data, Age).
REQ-015 A request SHALL be accepted at an edge where Valid and Ready are both high; Data and Dst SHALL be captured at that edge.
REQ-016 ReqN_Ready SHALL be high when slot N is empty or slot N is granted this cycle (back-to-back throughput of one per cycle per requester).
REQ-017 When at least one slot is full, exactly one slot SHALL be granted: REG_WE=0, REG_Dst/DIn taken from that slot, combinationally; the write commits at the next edge and the slot empties at that edge unless refilled.
REQ-018 When no slot is full, REG_WE SHALL be 1 and REG_Dst/DIn SHALL be 0.
REQ-019 Grant order: the slot accepted at an earlier edge SHALL win; on equal acceptance edge, the tie-break rule of REQ-027 applies.
REQ-020 Two full slots with the same Dst SHALL commit in acceptance order, so the later write is the final register value.
REQ-021 Pending SHALL be the OR of one-hot decodes of the Dst of every full slot; it updates at the same edges as slot Full flags.
REQ-022 Latency from acceptance to commit SHALL be 1 edge when uncontested and 2 edges when the other slot is older.
REQ-023 No accepted write SHALL ever be dropped or duplicated.

Reset
REQ-024 When Reset is high at an edge, both slots SHALL empty, Age/round-robin state SHALL clear, and any in-flight request SHALL be discarded.
REQ-025 After reset: REG_WE=1, REG_Dst=0, DIn=0, Pending=0, Req0_Ready=1, Req1_Ready=1.
REQ-026 While Reset is high, no request SHALL be accepted and REG_WE SHALL be 1.

Configuration
REQ-027 Macro REGFILE_WB_ARB_RR_EN: when defined, equal-age ties SHALL alternate by round-robin (the requester not granted last on a tie wins; requester 0 first after reset); when undefined, requester 0 SHALL always win ties.

Structure
REQ-028 Package regfile_pkg SHALL hold DataWidth/SelectSize defaults, NUM_REQ=2, and the slot record typedef.
REQ-029 Sub-module regfile_wb_slot SHALL implement one holding slot (capture, Full flag, release); instantiated twice.

Verification
REQ-030 Reset then idle -> REG_WE=1, Pending=0x00, both Ready=1.
REQ-031 Req0 writes R2<-0x00A0 alone -> REG_WE=0 with REG_Dst=2, DIn=0x00A0 for one cycle, Pending bit2 set for that cycle, register 2 reads 0x00A0 afterward.
REQ-032 Req0 R1<-0x000A at edge N, Req1 R3<-0x1234 at edge N+1 -> R1 commits at N+1, R3 commits at N+2.
REQ-033 Both requesters accepted at the same edge, R4<-0x1111 and R5<-0x2222, three times -> with REGFILE_WB_ARB_RR_EN grant order 0,1,1,0,0,1; without it 0,1,0,1,0,1.
REQ-034 Req1 R6<-0xBEEF, then Req0 R6<-0xCAFE one edge later -> final R6=0xCAFE, Pending bit6 clear after the second commit.
REQ-035 Reset asserted while both slots are full -> no write commits, Pending=0x00 on the next cycle, both Ready=1.
